rle_decode: RTL and testbench



---
 rtl/rle_pkg.sv | 27 ++
 rtl/rle_byte_packer.sv | 48 ++++
 rtl/rle_decode.sv | 203 ++++++++++++++++++++
 tb/tb_rle_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length codec: FSM states, word geometry
// and the bit offsets of the (count, byte) pair fields inside a 32-bit word.
package rle_pkg;

  localparam int WORD_W         = 32;
  localparam int PORT_ADDR_W    = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  // Pair layout, little-endian: pair0 in the low half, pair1 in the high half.
  // The encoder packs its output with these same offsets.
  localparam int COUNT0_LSB = 0;
  localparam int BYTE0_LSB  = 8;
  localparam int COUNT1_LSB = 16;
  localparam int BYTE1_LSB  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_EXPAND,
    ST_WRITE,
    ST_FLUSH,
    ST_FIN
  } state_t;

endpackage

// File: rtl/rle_byte_packer.sv
// Packs a stream of bytes little-endian into 32-bit words. The word output
// already contains any byte pushed in the current cycle, so the caller can
// register a complete word on the same edge that places its last byte.
module rle_byte_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  input  logic              i_clear,
  output logic              o_full,
  output logic [LANE_W-1:0] o_lane,
  output logic [WORD_W-1:0] o_word
);

  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] w_wordNext;
  logic [4:0]        w_laneLsb;

  assign w_laneLsb = {r_lane, 3'b000};

  // Merge the byte being pushed into its lane of the accumulated word
  always_comb begin
    w_wordNext = r_acc;
    if (i_push) begin
      w_wordNext[w_laneLsb +: 8] = i_byte;
    end
  end

  // Accumulate pushed bytes; clearing empties both the lanes and the data so
  // a later partial word carries zeros in its unused upper lanes
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (i_push) begin
      r_lane <= r_lane + 1'b1;
      r_acc  <= w_wordNext;
    end
  end

  assign o_full = i_push && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
  assign o_lane = r_lane;
  assign o_word = w_wordNext;

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads (count, byte) pairs from memory port A, expands
// them into plaintext bytes and writes packed words back through the same
// port. Reads and writes are never issued in the same cycle.
module rle_decode
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  state_t      r_state;
  state_t      r_resume;
  logic [31:0] r_rdAddr;
  logic [31:0] r_wrAddr;
  logic [31:0] r_pairsLeft;
  logic [7:0]  r_remaining;
  logic [7:0]  r_curByte;
  logic        r_pairSel;
  logic [7:0]  r_pair1Count;
  logic [7:0]  r_pair1Byte;
  logic [31:0] r_msgSize;
  logic        r_done;
  logic        r_we;
  logic [15:0] r_addr;
  logic [31:0] r_dataIn;

  logic              w_push;
  logic              w_exhausted;
  logic              w_clear;
  logic              w_full;
  logic [LANE_W-1:0] w_lane;
  logic [31:0]       w_packWord;
  logic [31:0]       w_pairsInit;
  logic [31:0]       w_pairsNext;
  logic [31:0]       w_rdAddrNext;
  state_t            w_afterPair;

  rle_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_byte  (r_curByte),
    .i_clear (w_clear),
    .o_full  (w_full),
    .o_lane  (w_lane),
    .o_word  (w_packWord)
  );

  assign w_pairsInit  = rle_size >> 1;
  assign w_pairsNext  = r_pairsLeft - 32'd1;
  assign w_rdAddrNext = r_rdAddr + 32'd4;
  assign w_push       = (r_state == ST_EXPAND) && (r_remaining != 8'd0);
  assign w_exhausted  = (r_state == ST_EXPAND) && (r_remaining <= 8'd1);
  assign w_clear      = (r_state == ST_WRITE) || (r_state == ST_FLUSH) ||
                        ((r_state == ST_IDLE) && start);

  // Decide where to go once the current pair runs out: finish (flushing any
  // partial word), move on to pair1 of the held word, or fetch the next word
  always_comb begin
    w_afterPair = ST_EXPAND;
    if (w_pairsNext == 32'd0) begin
      if (w_full || (!w_push && (w_lane == '0))) begin
        w_afterPair = ST_FIN;
      end else begin
        w_afterPair = ST_FLUSH;
      end
    end else if (r_pairSel) begin
      w_afterPair = ST_RD_REQ;
    end
  end

  // Main control FSM; port outputs are set on the edge entering the state
  // that uses them, so each read or write occupies exactly its own state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_resume     <= ST_IDLE;
      r_rdAddr     <= '0;
      r_wrAddr     <= '0;
      r_pairsLeft  <= '0;
      r_remaining  <= '0;
      r_curByte    <= '0;
      r_pairSel    <= 1'b0;
      r_pair1Count <= '0;
      r_pair1Byte  <= '0;
      r_msgSize    <= '0;
      r_done       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_dataIn     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rdAddr    <= rle_addr;
            r_wrAddr    <= message_addr;
            r_msgSize   <= '0;
            r_done      <= 1'b0;
            r_pairsLeft <= w_pairsInit;
            if (w_pairsInit == 32'd0) begin
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_RD_REQ;
              r_we    <= 1'b0;
              r_addr  <= rle_addr[15:0];
            end
          end
        end

        ST_RD_REQ: begin
          r_state <= ST_RD_CAP;
        end

        ST_RD_CAP: begin
          r_curByte    <= port_A_data_out[BYTE0_LSB +: 8];
          r_remaining  <= port_A_data_out[COUNT0_LSB +: 8];
          r_pair1Byte  <= port_A_data_out[BYTE1_LSB +: 8];
          r_pair1Count <= port_A_data_out[COUNT1_LSB +: 8];
          r_pairSel    <= 1'b0;
          r_state      <= ST_EXPAND;
        end

        ST_EXPAND: begin
          if (w_push) begin
            r_remaining <= r_remaining - 8'd1;
            r_msgSize   <= r_msgSize + 32'd1;
          end
          if (w_exhausted) begin
            r_pairsLeft <= w_pairsNext;
            if (w_pairsNext != 32'd0) begin
              if (!r_pairSel) begin
                r_curByte   <= r_pair1Byte;
                r_remaining <= r_pair1Count;
                r_pairSel   <= 1'b1;
              end else begin
                r_rdAddr <= w_rdAddrNext;
              end
            end
          end
          if (w_full) begin
            r_state  <= ST_WRITE;
            r_resume <= w_exhausted ? w_afterPair : ST_EXPAND;
            r_we     <= 1'b1;
            r_addr   <= r_wrAddr[15:0];
            r_dataIn <= w_packWord;
          end else if (w_exhausted) begin
            r_state <= w_afterPair;
            if (w_afterPair == ST_FLUSH) begin
              r_we     <= 1'b1;
              r_addr   <= r_wrAddr[15:0];
              r_dataIn <= w_packWord;
            end else if (w_afterPair == ST_RD_REQ) begin
              r_addr <= w_rdAddrNext[15:0];
            end
          end
        end

        ST_WRITE: begin
          r_we     <= 1'b0;
          r_wrAddr <= r_wrAddr + 32'd4;
          r_state  <= r_resume;
          if (r_resume == ST_RD_REQ) begin
            r_addr <= r_rdAddr[15:0];
          end
        end

        ST_FLUSH: begin
          r_we     <= 1'b0;
          r_wrAddr <= r_wrAddr + 32'd4;
          r_state  <= ST_FIN;
        end

        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign port_A_clk     = clk;
  assign port_A_addr    = r_addr;
  assign port_A_we      = r_we;
  assign port_A_data_in = r_dataIn;
  assign message_size   = r_msgSize;
  assign done           = r_done;

endmodule

// File: tb/tb_rle_decode.sv
// Scoreboard bench for rle_decode: each directed frame pushes its expected
// memory writes into a queue, and a monitor pops and compares every write
// the decoder issues on port A.
module tb_rle_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rle_addr;
  logic [31:0] rle_size;
  logic [31:0] message_addr;
  logic [31:0] message_size;
  logic        done;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mem [0:16383];

  rle_decode dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single-port memory model with one-cycle read latency
  always @(posedge clk) begin
    if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
    end
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr[15:0];
    e.data = data;
    expQ.push_back(e);
  endtask

  // Monitor: every write cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    wr_t e;
    if (port_A_we) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected write: got addr 0x%04h data 0x%08h, expected none",
                 port_A_addr, port_A_data_in);
      end else begin
        e = expQ.pop_front();
        checkOutput("write addr", {16'h0, port_A_addr}, {16'h0, e.addr});
        checkOutput("write data", port_A_data_in, e.data);
      end
    end
  end

  // Launch one frame and wait for done; optionally pulse start mid-frame,
  // which must be ignored
  task automatic applyStimulus(input logic [31:0] rAddr, input logic [31:0] rSize,
                               input logic [31:0] mAddr, input int expSize,
                               input int expLatency, input bit pokeStart);
    int cycles;
    @(negedge clk);
    rle_addr     = rAddr;
    rle_size     = rSize;
    message_addr = mAddr;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cycles = 1;
    checkOutput("done cleared after start", {31'h0, done}, 32'd0);
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      start = (pokeStart && cycles == 50);
    end
    start = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done timeout: got no done after %0d cycles, expected %0d",
               cycles, expLatency);
    end else begin
      checkOutput("done latency", cycles, expLatency);
    end
    checkOutput("message_size", message_size, expSize);
    checkOutput("outstanding writes", expQ.size(), 32'd0);
  endtask

  task automatic checkResetState();
    checkOutput("reset done", {31'h0, done}, 32'd0);
    checkOutput("reset message_size", message_size, 32'd0);
    checkOutput("reset we", {31'h0, port_A_we}, 32'd0);
    checkOutput("reset addr", {16'h0, port_A_addr}, 32'd0);
    checkOutput("reset data_in", port_A_data_in, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    reset        = 1'b1;
    start        = 1'b0;
    rle_addr     = '0;
    rle_size     = '0;
    message_addr = '0;
    repeat (2) @(negedge clk);
    checkResetState();
    checkOutput("port_A_clk follows clk", {31'h0, port_A_clk}, 32'd0);
    reset = 1'b0;

    // Two pairs with a trailing partial word; write address wraps past 0xFFFF
    mem[32'h100 >> 2] = 32'h4202_4103;
    expectWrite(32'h0003_FFFC, 32'h4241_4141);
    expectWrite(32'h0004_0000, 32'h0000_0042);
    applyStimulus(32'h100, 32'd4, 32'h0003_FFFC, 5, 11, 1'b0);

    // Exactly one full word, no flush
    mem[32'h110 >> 2] = 32'h0000_AB04;
    expectWrite(32'h1000, 32'hABAB_ABAB);
    applyStimulus(32'h110, 32'd2, 32'h1000, 4, 9, 1'b0);

    // Count-0 pair skipped
    mem[32'h120 >> 2] = 32'h5501_7700;
    expectWrite(32'h1100, 32'h0000_0055);
    applyStimulus(32'h120, 32'd4, 32'h1100, 1, 7, 1'b0);

    // Empty frames
    applyStimulus(32'h130, 32'd0, 32'h1200, 0, 2, 1'b0);
    applyStimulus(32'h130, 32'd1, 32'h1200, 0, 2, 1'b0);

    // Two input words, odd trailing byte ignored
    mem[32'h140 >> 2] = 32'h4202_4103;
    mem[32'h144 >> 2] = 32'h1101_3302;
    expectWrite(32'h1300, 32'h4241_4141);
    expectWrite(32'h1304, 32'h0033_3342);
    applyStimulus(32'h140, 32'd7, 32'h1300, 7, 15, 1'b0);

    // Maximum count, with a stray start mid-frame
    mem[32'h150 >> 2] = 32'h0000_CDFF;
    for (int i = 0; i < 63; i++) expectWrite(32'h2000 + 32'(4 * i), 32'hCDCD_CDCD);
    expectWrite(32'h20FC, 32'h00CD_CDCD);
    applyStimulus(32'h150, 32'd2, 32'h2000, 255, 323, 1'b1);

    // Reset during expansion of a 255-count pair
    for (int i = 0; i < 64; i++) expectWrite(32'h2800 + 32'(4 * i), 32'hCDCD_CDCD);
    @(negedge clk);
    rle_addr     = 32'h150;
    rle_size     = 32'd2;
    message_addr = 32'h2800;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetState();
    reset = 1'b0;
    expQ.delete();
    repeat (10) @(negedge clk);

    // Decoder works again after the aborted frame
    expectWrite(32'h3000, 32'h4241_4141);
    expectWrite(32'h3004, 32'h0000_0042);
    applyStimulus(32'h100, 32'd4, 32'h3000, 5, 11, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
